cpu7_inst_queue: RTL and testbench

Parametrised instruction queue between `cpu7_ifu` fetch return and `cpu7_exu` decode, replacing the single-port direct handoff. Accepts 128-bit fetch packets of 1–4 instructions and presents up to ISSUE_W in-order instructions per cycle. Also provides a branch-cancel flush and per-entry fetch-exception tagging, neither of which the direct handoff has.

---
 rtl/cpu7_inst_queue_if.sv | 38 +++
 rtl/cpu7_inst_queue.sv | 74 +++++++
 tb/tb_cpu7_inst_queue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_inst_queue_if.sv
// cpu7_inst_queue_if: fetch-to-decode queue bus; slave = queue, master = fetch/decode side.
// Ports: fq_in_* (fetch packet + ready), fq_flush, fq_out_* (issue slots + accept), fq_cnt, fq_empty.
interface cpu7_inst_queue_if #(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2,
  parameter int PC_W    = 32,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = $clog2(ISSUE_W + 1)
);
  logic                    fq_in_valid;
  logic                    fq_in_ready;
  logic [127:0]            fq_in_data;
  logic [1:0]              fq_in_count;
  logic [PC_W-1:0]         fq_in_pc;
  logic                    fq_in_ex;
  logic [5:0]              fq_in_exccode;
  logic                    fq_flush;
  logic [ISSUE_W-1:0]      fq_out_valid;
  logic [32*ISSUE_W-1:0]   fq_out_inst;
  logic [PC_W*ISSUE_W-1:0] fq_out_pc;
  logic [ISSUE_W-1:0]      fq_out_ex;
  logic [6*ISSUE_W-1:0]    fq_out_exccode;
  logic [CW-1:0]           fq_out_accept;
  logic [AW:0]             fq_cnt;
  logic                    fq_empty;
  modport slave (
    input  fq_in_valid, fq_in_data, fq_in_count, fq_in_pc, fq_in_ex, fq_in_exccode,
    input  fq_flush, fq_out_accept,
    output fq_in_ready, fq_out_valid, fq_out_inst, fq_out_pc, fq_out_ex, fq_out_exccode,
    output fq_cnt, fq_empty
  );
  modport master (
    output fq_in_valid, fq_in_data, fq_in_count, fq_in_pc, fq_in_ex, fq_in_exccode,
    output fq_flush, fq_out_accept,
    input  fq_in_ready, fq_out_valid, fq_out_inst, fq_out_pc, fq_out_ex, fq_out_exccode,
    input  fq_cnt, fq_empty
  );
endinterface

// File: rtl/cpu7_inst_queue.sv
// cpu7_inst_queue: circular instruction queue taking 1-4 inst fetch packets, issuing up to ISSUE_W in order.
// Ports: clk, reset (async, active-high), q (cpu7_inst_queue_if.slave: fetch in, issue slots out, flush, occupancy).
module cpu7_inst_queue #(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2,
  parameter int PC_W    = 32,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = $clog2(ISSUE_W + 1)
) (
  input logic clk,
  input logic reset,
  cpu7_inst_queue_if.slave q
);
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     cnt;
  logic [31:0]     inst_m [DEPTH];
  logic [PC_W-3:0] pc_m   [DEPTH];
  logic            ex_m   [DEPTH];
  logic [5:0]      exc_m  [DEPTH];
  logic            enq, blk, v;
  logic [2:0]      n_enq;
  logic [CW-1:0]   nv, acc;
  // ready only looks at registered occupancy so there is no accept-to-ready path
  assign q.fq_in_ready = cnt <= (AW+1)'(DEPTH - 4);
  assign q.fq_cnt      = cnt;
  assign q.fq_empty    = cnt == '0;
  assign enq   = q.fq_in_valid & q.fq_in_ready & ~q.fq_flush;
  // an exception packet collapses to a single entry carrying inst 0
  assign n_enq = q.fq_in_ex ? 3'd1 : {1'b0, q.fq_in_count} + 3'd1;
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (enq && 3'(k) < n_enq) begin
        inst_m[wr_ptr + AW'(k)] <= q.fq_in_data[32*k +: 32];
        pc_m[wr_ptr + AW'(k)]   <= q.fq_in_pc[PC_W-1:2] + (PC_W-2)'(k);
        ex_m[wr_ptr + AW'(k)]   <= q.fq_in_ex;
        exc_m[wr_ptr + AW'(k)]  <= q.fq_in_exccode;
      end
  for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
    logic [AW-1:0] idx;
    assign idx = rd_ptr + AW'(i);
    assign q.fq_out_inst[32*i +: 32]       = inst_m[idx];
    assign q.fq_out_pc[PC_W*i +: PC_W]     = {pc_m[idx], 2'b00};
    assign q.fq_out_ex[i]                  = ex_m[idx];
    assign q.fq_out_exccode[6*i +: 6]      = exc_m[idx];
  end
  // an exception entry ends the valid run so younger entries wait behind it
  always_comb begin
    blk = 1'b0;
    nv  = '0;
    v   = 1'b0;
    q.fq_out_valid = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      v = ((AW+1)'(i) < cnt) && !blk;
      q.fq_out_valid[i] = v;
      nv  = nv + CW'(v);
      blk = blk | ex_m[rd_ptr + AW'(i)];
    end
  end
  assign acc = q.fq_out_accept < nv ? q.fq_out_accept : nv;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (q.fq_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(acc);
      wr_ptr <= wr_ptr + (enq ? AW'(n_enq) : AW'(0));
      cnt    <= cnt + (enq ? (AW+1)'(n_enq) : (AW+1)'(0)) - (AW+1)'(acc);
    end
endmodule

// File: tb/tb_cpu7_inst_queue.sv
// tb_cpu7_inst_queue: directed bench for cpu7_inst_queue with DEPTH=8, ISSUE_W=2.
module tb_cpu7_inst_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  cpu7_inst_queue_if #(.DEPTH(8), .ISSUE_W(2), .PC_W(32)) q ();
  cpu7_inst_queue #(.DEPTH(8), .ISSUE_W(2), .PC_W(32)) dut (.clk(clk), .reset(reset), .q(q));
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c, input logic [31:0] pc, input logic [127:0] d,
                      input logic ex, input logic [5:0] ec);
    q.fq_in_valid = 1'b1;
    q.fq_in_count = c;
    q.fq_in_pc = pc;
    q.fq_in_data = d;
    q.fq_in_ex = ex;
    q.fq_in_exccode = ec;
  endtask

  task automatic idle();
    q.fq_in_valid = 1'b0;
    q.fq_in_ex = 1'b0;
    q.fq_out_accept = 2'd0;
    q.fq_flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    q.fq_in_data = '0; q.fq_in_count = 2'd0; q.fq_in_pc = '0; q.fq_in_exccode = '0;
    #2;
    n_cmp++; if (q.fq_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", q.fq_cnt); end
    n_cmp++; if (q.fq_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", q.fq_empty); end
    n_cmp++; if (q.fq_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", q.fq_in_ready); end
    n_cmp++; if (q.fq_out_valid !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", q.fq_out_valid); end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    push(2'd3, 32'h1c000000, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 1'b0, 6'd0);
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd4) begin n_bad++; $display("FAIL basic_cnt got %0d want 4", q.fq_cnt); end
    n_cmp++; if (q.fq_out_valid !== 2'b11) begin n_bad++; $display("FAIL basic_valid got %b want 11", q.fq_out_valid); end
    n_cmp++; if (q.fq_out_inst !== {32'hBBBB0002, 32'hAAAA0001}) begin n_bad++; $display("FAIL basic_inst01 got %h want bbbb0002aaaa0001", q.fq_out_inst); end
    n_cmp++; if (q.fq_out_pc !== {32'h1c000004, 32'h1c000000}) begin n_bad++; $display("FAIL basic_pc01 got %h want 1c0000041c000000", q.fq_out_pc); end
    q.fq_out_accept = 2'd2;
    cyc();
    n_cmp++; if (q.fq_out_inst !== {32'hDDDD0004, 32'hCCCC0003}) begin n_bad++; $display("FAIL basic_inst23 got %h want dddd0004cccc0003", q.fq_out_inst); end
    n_cmp++; if (q.fq_out_pc !== {32'h1c00000c, 32'h1c000008}) begin n_bad++; $display("FAIL basic_pc23 got %h want 1c00000c1c000008", q.fq_out_pc); end
    n_cmp++; if (q.fq_out_valid !== 2'b11) begin n_bad++; $display("FAIL basic_valid23 got %b want 11", q.fq_out_valid); end
    cyc();
    idle();
    n_cmp++; if (q.fq_empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty got %b want 1", q.fq_empty); end
    n_cmp++; if (q.fq_out_valid !== 2'b00) begin n_bad++; $display("FAIL basic_valid_end got %b want 00", q.fq_out_valid); end
  endtask

  task automatic test_fill();
    push(2'd3, 32'h00000100, {32'h11, 32'h10, 32'h0F, 32'h0E}, 1'b0, 6'd0);
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd4 || q.fq_in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_half got cnt=%0d rdy=%b want 4/1", q.fq_cnt, q.fq_in_ready); end
    push(2'd3, 32'h00000200, {32'h24, 32'h23, 32'h22, 32'h21}, 1'b0, 6'd0);
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd8 || q.fq_in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full got cnt=%0d rdy=%b want 8/0", q.fq_cnt, q.fq_in_ready); end
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd8) begin n_bad++; $display("FAIL fill_blocked got %0d want 8", q.fq_cnt); end
    idle();
    q.fq_out_accept = 2'd2;
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd6 || q.fq_in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_drain6 got cnt=%0d rdy=%b want 6/0", q.fq_cnt, q.fq_in_ready); end
    cyc();
    q.fq_out_accept = 2'd0;
    n_cmp++; if (q.fq_cnt !== 4'd4 || q.fq_in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_drain4 got cnt=%0d rdy=%b want 4/1", q.fq_cnt, q.fq_in_ready); end
    n_cmp++; if (q.fq_out_inst[31:0] !== 32'h21 || q.fq_out_pc[31:0] !== 32'h200) begin n_bad++; $display("FAIL fill_head got inst=%h pc=%h want 21/200", q.fq_out_inst[31:0], q.fq_out_pc[31:0]); end
    push(2'd0, 32'h00000300, {96'd0, 32'h31}, 1'b0, 6'd0);
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd5 || q.fq_in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_cnt5 got cnt=%0d rdy=%b want 5/0", q.fq_cnt, q.fq_in_ready); end
    push(2'd3, 32'h00000400, {32'h44, 32'h43, 32'h42, 32'h41}, 1'b0, 6'd0);
    q.fq_out_accept = 2'd2;
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd3) begin n_bad++; $display("FAIL fill_no_bypass got %0d want 3", q.fq_cnt); end
    q.fq_flush = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_exception();
    push(2'd0, 32'h00003000, {96'd0, 32'h5A5A0001}, 1'b0, 6'd0);
    cyc();
    push(2'd3, 32'h00004000, {32'h4, 32'h3, 32'h2, 32'hE0E0E0E0}, 1'b1, 6'h08);
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd2) begin n_bad++; $display("FAIL exc_cnt got %0d want 2", q.fq_cnt); end
    n_cmp++; if (q.fq_out_valid !== 2'b11) begin n_bad++; $display("FAIL exc_valid got %b want 11", q.fq_out_valid); end
    n_cmp++; if (q.fq_out_inst !== {32'hE0E0E0E0, 32'h5A5A0001}) begin n_bad++; $display("FAIL exc_inst got %h want e0e0e0e05a5a0001", q.fq_out_inst); end
    n_cmp++; if (q.fq_out_ex !== 2'b10 || q.fq_out_exccode[11:6] !== 6'h08) begin n_bad++; $display("FAIL exc_tag got ex=%b code=%h want 10/08", q.fq_out_ex, q.fq_out_exccode[11:6]); end
    n_cmp++; if (q.fq_out_pc[63:32] !== 32'h4000) begin n_bad++; $display("FAIL exc_pc got %h want 4000", q.fq_out_pc[63:32]); end
    q.fq_out_accept = 2'd1;
    push(2'd0, 32'h00005000, {96'd0, 32'h7E7E0001}, 1'b0, 6'd0);
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd2 || q.fq_out_valid !== 2'b01) begin n_bad++; $display("FAIL exc_block got cnt=%0d valid=%b want 2/01", q.fq_cnt, q.fq_out_valid); end
    n_cmp++; if (q.fq_out_ex[0] !== 1'b1 || q.fq_out_inst[31:0] !== 32'hE0E0E0E0) begin n_bad++; $display("FAIL exc_head got ex=%b inst=%h want 1/e0e0e0e0", q.fq_out_ex[0], q.fq_out_inst[31:0]); end
    q.fq_out_accept = 2'd2;
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd1 || q.fq_out_valid !== 2'b01) begin n_bad++; $display("FAIL exc_clamp got cnt=%0d valid=%b want 1/01", q.fq_cnt, q.fq_out_valid); end
    n_cmp++; if (q.fq_out_inst[31:0] !== 32'h7E7E0001 || q.fq_out_ex[0] !== 1'b0) begin n_bad++; $display("FAIL exc_after got inst=%h ex=%b want 7e7e0001/0", q.fq_out_inst[31:0], q.fq_out_ex[0]); end
    cyc();
    idle();
    n_cmp++; if (q.fq_empty !== 1'b1) begin n_bad++; $display("FAIL exc_empty got %b want 1", q.fq_empty); end
  endtask

  task automatic test_flush();
    push(2'd3, 32'h00006000, {32'h64, 32'h63, 32'h62, 32'h61}, 1'b0, 6'd0);
    cyc();
    push(2'd0, 32'h00006010, {96'd0, 32'h65}, 1'b0, 6'd0);
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd5) begin n_bad++; $display("FAIL flush_pre got %0d want 5", q.fq_cnt); end
    q.fq_flush = 1'b1;
    q.fq_out_accept = 2'd2;
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd0 || q.fq_out_valid !== 2'b00 || q.fq_in_ready !== 1'b1) begin n_bad++; $display("FAIL flush5 got cnt=%0d valid=%b rdy=%b want 0/00/1", q.fq_cnt, q.fq_out_valid, q.fq_in_ready); end
    push(2'd0, 32'h00007000, {96'd0, 32'h71}, 1'b0, 6'd0);
    cyc();
    push(2'd3, 32'h00008000, {32'h84, 32'h83, 32'h82, 32'h81}, 1'b0, 6'd0);
    q.fq_flush = 1'b1;
    q.fq_out_accept = 2'd1;
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd0 || q.fq_empty !== 1'b1) begin n_bad++; $display("FAIL flush_enq got cnt=%0d empty=%b want 0/1", q.fq_cnt, q.fq_empty); end
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd0 || q.fq_out_valid !== 2'b00) begin n_bad++; $display("FAIL flush_late got cnt=%0d valid=%b want 0/00", q.fq_cnt, q.fq_out_valid); end
  endtask

  task automatic test_wrap();
    push(2'd3, 32'h00009000, {32'h94, 32'h93, 32'h92, 32'h91}, 1'b0, 6'd0);
    cyc();
    idle();
    q.fq_out_accept = 2'd2;
    cyc();
    cyc();
    push(2'd1, 32'h0000a000, {64'd0, 32'hA2, 32'hA1}, 1'b0, 6'd0);
    q.fq_out_accept = 2'd0;
    cyc();
    idle();
    q.fq_out_accept = 2'd2;
    cyc();
    n_cmp++; if (q.fq_cnt !== 4'd0) begin n_bad++; $display("FAIL wrap_setup got %0d want 0", q.fq_cnt); end
    push(2'd3, 32'hfffffff8, {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 1'b0, 6'd0);
    q.fq_out_accept = 2'd0;
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd4) begin n_bad++; $display("FAIL wrap_cnt got %0d want 4", q.fq_cnt); end
    n_cmp++; if (q.fq_out_inst !== {32'hF2, 32'hF1} || q.fq_out_pc !== {32'hfffffffc, 32'hfffffff8}) begin n_bad++; $display("FAIL wrap_first got inst=%h pc=%h want f2f1/fffffffcfffffff8", q.fq_out_inst, q.fq_out_pc); end
    q.fq_out_accept = 2'd2;
    cyc();
    n_cmp++; if (q.fq_out_inst !== {32'hF4, 32'hF3} || q.fq_out_pc !== {32'h4, 32'h0}) begin n_bad++; $display("FAIL wrap_second got inst=%h pc=%h want f4f3/0000000400000000", q.fq_out_inst, q.fq_out_pc); end
    cyc();
    idle();
    n_cmp++; if (q.fq_empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got %b want 1", q.fq_empty); end
  endtask

  task automatic test_async_reset();
    push(2'd2, 32'h0000b000, {32'h0, 32'hB3, 32'hB2, 32'hB1}, 1'b0, 6'd0);
    cyc();
    idle();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (q.fq_cnt !== 4'd0 || q.fq_out_valid !== 2'b00 || q.fq_empty !== 1'b1) begin n_bad++; $display("FAIL async_rst got cnt=%0d valid=%b empty=%b want 0/00/1", q.fq_cnt, q.fq_out_valid, q.fq_empty); end
    #1;
    reset = 1'b0;
    push(2'd0, 32'h0000c000, {96'd0, 32'hC1}, 1'b0, 6'd0);
    cyc();
    idle();
    n_cmp++; if (q.fq_cnt !== 4'd1 || q.fq_out_inst[31:0] !== 32'hC1 || q.fq_out_pc[31:0] !== 32'hc000) begin n_bad++; $display("FAIL post_rst got cnt=%0d inst=%h pc=%h want 1/c1/c000", q.fq_cnt, q.fq_out_inst[31:0], q.fq_out_pc[31:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_exception();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule
